// File: rtl/cnt_bcd_display_pkg.sv
// Shared types and constants for the BCD conversion and multiplexed display path.
// Holds the converter state encoding, digit geometry and the active-low segment table.
package cnt_disp_pkg;

  localparam int NUM_DIGITS = 6;
  localparam int BIN_W      = 7;
  localparam int BCD_W      = 12;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } conv_state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Index 0 sits in the least significant slot: SEG_LUT[d] is the code for digit d.
  localparam logic [9:0][6:0] SEG_LUT = {
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
    7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic [3:0] add3_nibble(input logic [3:0] nib);
    logic [3:0] res;
    if (nib >= 4'd5) begin
      res = nib + 4'd3;
    end else begin
      res = nib;
    end
    return res;
  endfunction

  function automatic logic [BCD_W-1:0] add3_adjust(input logic [BCD_W-1:0] bcd);
    return {add3_nibble(bcd[11:8]), add3_nibble(bcd[7:4]), add3_nibble(bcd[3:0])};
  endfunction

  function automatic logic [6:0] seg_encode(input logic [3:0] digit, input logic blank);
    logic [6:0] code;
    if (blank || (digit > 4'd9)) begin
      code = SEG_BLANK;
    end else begin
      code = SEG_LUT[digit];
    end
    return code;
  endfunction

endpackage

// File: rtl/bcd7_conv.sv
// Sequential shift-add-3 converter for one 7-bit value: LOAD, seven SHIFT cycles, COMMIT.
// The result is stable on bcd while done is high (the COMMIT cycle).
module bcd7_conv
  import cnt_disp_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic [BCD_W-1:0] bcd,
  output logic             done
);

  conv_state_e      state_r;
  conv_state_e      state_s;
  logic [BIN_W-1:0] bin_r;
  logic [BCD_W-1:0] bcd_r;
  logic [2:0]       iter_r;
  logic [BCD_W-1:0] adj_s;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_LOAD;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_LOAD: begin
        if (start) begin
          state_s = ST_SHIFT;
        end else begin
          state_s = ST_LOAD;
        end
      end
      ST_SHIFT: begin
        if (iter_r == 3'd6) begin
          state_s = ST_COMMIT;
        end else begin
          state_s = ST_SHIFT;
        end
      end
      ST_COMMIT: state_s = ST_LOAD;
      default:   state_s = ST_LOAD;
    endcase
  end

  assign adj_s = add3_adjust(bcd_r);

  // Shift register, BCD accumulator and iteration count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_r  <= {BIN_W{1'b0}};
      bcd_r  <= {BCD_W{1'b0}};
      iter_r <= 3'd0;
    end else begin
      case (state_r)
        ST_LOAD: begin
          if (start) begin
            bin_r <= bin;
          end else begin
            bin_r <= bin_r;
          end
          bcd_r  <= {BCD_W{1'b0}};
          iter_r <= 3'd0;
        end
        ST_SHIFT: begin
          // Adjust first, then shift {bcd, bin} left by one as a single 19-bit word.
          {bcd_r, bin_r} <= {adj_s[BCD_W-2:0], bin_r, 1'b0};
          iter_r         <= iter_r + 3'd1;
        end
        ST_COMMIT: begin
          bcd_r  <= bcd_r;
          iter_r <= iter_r;
        end
        default: begin
          bin_r  <= {BIN_W{1'b0}};
          bcd_r  <= {BCD_W{1'b0}};
          iter_r <= 3'd0;
        end
      endcase
    end
  end

  assign bcd  = bcd_r;
  assign done = (state_r == ST_COMMIT);

endmodule

// File: rtl/cnt_bcd_display.sv
// Alternately converts the two counter channels to BCD and scans them onto a
// six-digit common-anode display with per-channel leading-zero blanking.
module cnt_bcd_display
  import cnt_disp_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [BIN_W-1:0] cnt,
  input  logic [BIN_W-1:0] cnt2,
  output logic [BCD_W-1:0] bcd_a,
  output logic [BCD_W-1:0] bcd_b,
  output logic             conv_done,
  output logic [6:0]       seg,
  output logic [NUM_DIGITS-1:0] an
);

  localparam int PRESC_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(SCAN_DIV - 1);

  logic                  sel_r;
  logic [BCD_W-1:0]      bank_a_r;
  logic [BCD_W-1:0]      bank_b_r;
  logic                  conv_done_r;
  logic [PRESC_W-1:0]    presc_r;
  logic [2:0]            dig_r;
  logic [6:0]            seg_r;
  logic [NUM_DIGITS-1:0] an_r;

  logic [BIN_W-1:0]      conv_bin_s;
  logic [BCD_W-1:0]      conv_bcd_s;
  logic                  conv_fin_s;
  logic [3:0]            nib_s;
  logic                  blank_s;

  assign conv_bin_s = sel_r ? cnt2 : cnt;

  bcd7_conv u_conv (
    .clk   (clk),
    .rst_n (rst_n),
    .start (1'b1),
    .bin   (conv_bin_s),
    .bcd   (conv_bcd_s),
    .done  (conv_fin_s)
  );

  // Channel sequencing and result banks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_r       <= 1'b0;
      bank_a_r    <= {BCD_W{1'b0}};
      bank_b_r    <= {BCD_W{1'b0}};
      conv_done_r <= 1'b0;
    end else if (conv_fin_s) begin
      if (sel_r) begin
        bank_b_r <= conv_bcd_s;
      end else begin
        bank_a_r <= conv_bcd_s;
      end
      sel_r       <= ~sel_r;
      conv_done_r <= sel_r;
    end else begin
      conv_done_r <= 1'b0;
    end
  end

  // Scan prescaler and digit index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_r <= {PRESC_W{1'b0}};
      dig_r   <= 3'd0;
    end else if (presc_r == PRESC_LAST) begin
      presc_r <= {PRESC_W{1'b0}};
      if (dig_r == 3'(NUM_DIGITS - 1)) begin
        dig_r <= 3'd0;
      end else begin
        dig_r <= dig_r + 3'd1;
      end
    end else begin
      presc_r <= presc_r + {{(PRESC_W-1){1'b0}}, 1'b1};
    end
  end

  // Digit select with leading-zero blanking; ones are never blanked
  always_comb begin
    nib_s   = 4'd0;
    blank_s = 1'b1;
    case (dig_r)
      3'd0: begin nib_s = bank_a_r[3:0];  blank_s = 1'b0; end
      3'd1: begin nib_s = bank_a_r[7:4];  blank_s = (bank_a_r[11:4] == 8'd0); end
      3'd2: begin nib_s = bank_a_r[11:8]; blank_s = (bank_a_r[11:8] == 4'd0); end
      3'd3: begin nib_s = bank_b_r[3:0];  blank_s = 1'b0; end
      3'd4: begin nib_s = bank_b_r[7:4];  blank_s = (bank_b_r[11:4] == 8'd0); end
      3'd5: begin nib_s = bank_b_r[11:8]; blank_s = (bank_b_r[11:8] == 4'd0); end
      default: begin nib_s = 4'd0; blank_s = 1'b1; end
    endcase
  end

  // Registered segment and anode drive
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_r <= 7'h40;
      an_r  <= 6'b111110;
    end else begin
      seg_r <= seg_encode(nib_s, blank_s);
      an_r  <= ~(6'b000001 << dig_r);
    end
  end

  assign bcd_a     = bank_a_r;
  assign bcd_b     = bank_b_r;
  assign conv_done = conv_done_r;
  assign seg       = seg_r;
  assign an        = an_r;

endmodule

// File: tb/tb_cnt_bcd_display.sv
// Directed self-checking bench for cnt_bcd_display with a fast scan divider.
module tb_cnt_bcd_display;

  logic        clk;
  logic        rst_n;
  logic [6:0]  cnt;
  logic [6:0]  cnt2;
  logic [11:0] bcd_a;
  logic [11:0] bcd_b;
  logic        conv_done;
  logic [6:0]  seg;
  logic [5:0]  an;

  int errors = 0;
  int checks = 0;

  cnt_bcd_display #(.SCAN_DIV(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cnt       (cnt),
    .cnt2      (cnt2),
    .bcd_a     (bcd_a),
    .bcd_b     (bcd_b),
    .conv_done (conv_done),
    .seg       (seg),
    .an        (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns the number of negedges waited until conv_done is seen, 0 on timeout.
  task automatic wait_done(output int waited);
    waited = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (conv_done === 1'b1) begin
        waited = k;
        break;
      end
    end
    if (waited == 0) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic sweep(input string tag, input logic [5:0][6:0] exp_seg);
    logic [5:0] exp_an;
    bit found;
    for (int i = 0; i < 6; i++) begin
      exp_an = ~(6'b000001 << i);
      found = 1'b0;
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        if (an === exp_an) begin
          found = 1'b1;
          break;
        end
      end
      if (!found) check({tag, "_an_timeout"}, {26'd0, an}, {26'd0, exp_an});
      check({tag, "_seg"}, {25'd0, seg}, {25'd0, exp_seg[i]});
    end
  endtask

  function automatic logic [11:0] ref_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  int w;
  int first;

  initial begin
    rst_n = 1'b0;
    cnt   = 7'd127;
    cnt2  = 7'd45;
    step(3);
    check("rst_bcd_a", {20'd0, bcd_a}, 32'h0);
    check("rst_bcd_b", {20'd0, bcd_b}, 32'h0);
    check("rst_an", {26'd0, an}, {26'd0, 6'b111110});
    check("rst_seg", {25'd0, seg}, {25'd0, 7'h40});
    check("rst_done", {31'd0, conv_done}, 32'd0);

    // Release, run into SHIFT, then abort with reset
    rst_n = 1'b1;
    step(5);
    rst_n = 1'b0;
    step(1);
    check("rerst_bcd_a", {20'd0, bcd_a}, 32'h0);
    check("rerst_an", {26'd0, an}, {26'd0, 6'b111110});
    check("rerst_done", {31'd0, conv_done}, 32'd0);
    rst_n = 1'b1;

    wait_done(first);
    check("first_done_edge", first, 32'd18);
    check("conv_bcd_a", {20'd0, bcd_a}, 32'h127);
    check("conv_bcd_b", {20'd0, bcd_b}, 32'h045);
    wait_done(w);
    check("done_period", w, 32'd18);

    sweep("scan", {7'h7F, 7'h19, 7'h12, 7'h79, 7'h24, 7'h78});

    cnt  = 7'd5;
    cnt2 = 7'd0;
    wait_done(w);
    wait_done(w);
    check("blank_bcd_a", {20'd0, bcd_a}, 32'h005);
    check("blank_bcd_b", {20'd0, bcd_b}, 32'h000);
    sweep("blank", {7'h7F, 7'h7F, 7'h40, 7'h7F, 7'h7F, 7'h12});

    // Full channel A sweep, one value per A+B refresh
    wait_done(w);
    for (int v = 0; v < 128; v++) begin
      cnt = 7'(v);
      wait_done(w);
      check($sformatf("sweep_%0d", v), {20'd0, bcd_a}, {20'd0, ref_bcd(v)});
    end
    check("sweep_bcd_b", {20'd0, bcd_b}, 32'h000);

    // Mid-conversion input change must not leak into the running conversion
    cnt = 7'd10;
    wait_done(w);
    step(2);
    cnt = 7'd20;
    step(7);
    check("mid_first", {20'd0, bcd_a}, 32'h010);
    wait_done(w);
    step(9);
    check("mid_next", {20'd0, bcd_a}, 32'h020);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cnt_bcd_display.md
# cnt_bcd_display

Downstream consumer of `pipeline_counter`: samples its two 7-bit count outputs, converts each to 3-digit BCD with a sequential shift-add-3 engine, and drives a 6-digit multiplexed common-anode 7-segment display. Also exposes the converted BCD values so benches and other logic can check them without decoding segments.

## Interface
- `SCAN_DIV`, default 50000: clock cycles per digit slot. Legal range is ≥ 2; benches use 4.
- `clk`, input, 1: system clock; all logic is on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `cnt`, input, 7: channel A value (0..127), from `pipeline_counter.cnt`.
- `cnt2`, input, 7: channel B value (0..127), from `pipeline_counter.cnt2`.
- `bcd_a`, output, 12: channel A BCD as {hundreds, tens, ones}.
- `bcd_b`, output, 12: channel B BCD, same format.
- `conv_done`, output, 1: one-cycle pulse when a channel B commit completes, i.e. a full A+B refresh.
- `seg`, output, 7: segments {g,f,e,d,c,b,a}, active-low.
- `an`, output, 6: digit enables, active-low one-hot.

## Operation
- Converter FSM states: LOAD → SHIFT → COMMIT → LOAD, running continuously. Register `sel` picks the channel: 0 = A, 1 = B.
- LOAD, 1 cycle:
  - Capture `cnt` (sel=0) or `cnt2` (sel=1) into a 7-bit shift register.
  - Clear the 12-bit BCD accumulator and iteration count.
- SHIFT, exactly 7 cycles. Each cycle:
  - Add 3 to every BCD nibble that is ≥ 5.
  - Then shift {bcd, bin} left by 1.
- COMMIT, 1 cycle:
  - Write the accumulator to `bcd_a` (sel=0) or `bcd_b` (sel=1).
  - Toggle `sel`.
  - If sel was 1, assert `conv_done`.
- Input changes during SHIFT or COMMIT are ignored until the next LOAD for that channel.
- Scan logic:
  - A prescaler counts 0..SCAN_DIV-1. At terminal count it advances digit index `dig` 0→1→…→5→0 and wraps to 0.
  - Digit mapping: 0/1/2 = A ones/tens/hundreds; 3/4/5 = B ones/tens/hundreds.
- Leading-zero blanking, applied per channel:
  - Hundreds digit is blank if it is 0.
  - Tens digit is blank if both hundreds and tens are 0.
  - Ones digit is never blank.
  - Blank drives `seg` = 7'h7F.
- Segment codes (active-low): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex).

## Timing
- Reset values:
  - FSM = LOAD, sel=0.
  - `bcd_a` = `bcd_b` = 0, `conv_done` = 0.
  - Prescaler = 0, `dig` = 0.
  - `an` = 6'b111110, `seg` = 7'h40.
- Conversion period is 9 cycles per channel, 18 per A+B pair.
- Latency:
  - A value sampled at a LOAD edge is visible on `bcd_x` 9 edges later.
  - Worst case from an input change to `bcd_x` updated is 27 cycles.
- `seg` and `an` are registered from (`dig`, current bank): 1-cycle latency after a `dig` or bank change.
  - If a bank update and a scan tick fall on the same edge, the displayed value follows the new index one cycle later and the new bank from then on.
- `conv_done` repeats every 18 cycles. The first pulse comes on the 18th edge after reset release.
- Reset mid-conversion aborts it; the partial result is never committed.

## Structure
- Package `cnt_disp_pkg` holds:
  - FSM state enum.
  - `NUM_DIGITS` = 6 and `BIN_W` = 7.
  - The 10-entry segment lookup constant and `SEG_BLANK`.
- Sub-module `bcd7_conv`: the LOAD/SHIFT/COMMIT engine for one 7-bit value.
  - Ports: `start`, `bin`, `bcd`, `done`.
- Top level: channel sequencing, the two banks, prescaler, blanking, segment decode.

## Test plan
- **Reset:** hold `rst_n`=0, with a mid-SHIFT re-assert. Expect `bcd_a`=`bcd_b`=0, `an`=111110, `seg`=40, `conv_done`=0. After release, first `conv_done` on edge 18.
- **Conversion:** `cnt`=127, `cnt2`=45 held. Within 27 cycles expect `bcd_a`=12'h127 and `bcd_b`=12'h045.
- **Scan sweep** (SCAN_DIV=4, values as above). Over 24 cycles `an` walks 111110→111101→…→011111, and `seg` reads 78, 24, 79, 12, 19, 7F (B hundreds blanked).
- **Blanking:** `cnt`=5, `cnt2`=0. Expect A digits 12, 7F, 7F and B digits 40, 7F, 7F.
- **Corner values:** sweep `cnt` 0..127 against a reference model, checking `bcd_a` after each `conv_done`. Include 9→10 and 99→100.
- **Mid-conversion change:** change `cnt` from 10 to 20 two cycles after channel A LOAD. Expect the commit to give `bcd_a`=12'h010 and the next A commit to give 12'h020.
